// File: rtl/frame_bank_sched.sv
// Ping-pong frame capture scheduler: gates the recorder, assigns a free bank per
// frame, generates write addresses and hands finished banks to host readout.
// state   | meaning
// IDLE    | no sequence active
// WAIT_FS | armed, waiting for a frame start with a free bank
// CAPT    | recording a frame into cur_bank
// CLOSE   | 2-cycle tail for late recorder words, then bank handed over
module frame_bank_sched #(
  parameter int AW          = 18,
  parameter int FRAME_WORDS = 259200
) (
  input  logic          par_clock,
  input  logic          rst_n,
  input  logic          arm,
  input  logic [7:0]    n_frames,
  input  logic          abort,
  input  logic          FS,
  input  logic          FE,
  output logic          REC,
  input  logic          we_in,
  input  logic [63:0]   pixels_in,
  output logic          mem_we,
  output logic [AW:0]   mem_addr,
  output logic [63:0]   mem_data,
  output logic [1:0]    bank_full,
  input  logic [1:0]    host_release,
  output logic          busy,
  output logic          frame_err,
  output logic [7:0]    drop_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_FS, CAPT, CLOSE} state_t;

  localparam logic [AW-1:0] FW = AW'(FRAME_WORDS);

  state_t        state, state_nx;
  logic [AW-1:0] word_addr, wa_after;
  logic [7:0]    remaining;
  logic          cont, cur_bank, last_bank, close_cnt;
  logic          chosen, bank_ok, start, take, drop, close_done;
  logic          wr_active, wr_take, wr_over;
  logic [1:0]    bank_set;

  always_comb begin
    state_nx   = state;
    chosen     = bank_full[~last_bank] ? last_bank : ~last_bank;
    bank_ok    = !bank_full[chosen];
    start      = 1'b0;
    take       = 1'b0;
    drop       = 1'b0;
    close_done = 1'b0;
    case (state)
      IDLE: if (arm) begin
        start    = 1'b1;
        state_nx = WAIT_FS;
      end
      WAIT_FS: if (FS) begin
        if (bank_ok) begin
          take     = 1'b1;
          state_nx = CAPT;
        end else begin
          drop = 1'b1;
        end
      end
      CAPT: if (FE) state_nx = CLOSE;
      CLOSE: if (close_cnt) begin
        close_done = 1'b1;
        state_nx   = (!cont && remaining == 8'd1) ? IDLE : WAIT_FS;
      end
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx   = IDLE;
      start      = 1'b0;
      take       = 1'b0;
      drop       = 1'b0;
      close_done = 1'b0;
    end
  end

  // Words past a full frame are dropped rather than wrapping into the bank start.
  assign wr_active = (state == CAPT || state == CLOSE) && !abort;
  assign wr_take   = wr_active && we_in && (word_addr != FW);
  assign wr_over   = wr_active && we_in && (word_addr == FW);
  assign wa_after  = wr_take ? word_addr + 1'b1 : word_addr;
  assign bank_set  = close_done ? (2'b01 << cur_bank) : 2'b00;

  always_ff @(posedge par_clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      REC       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      bank_full <= 2'b00;
      frame_err <= 1'b0;
      drop_cnt  <= 8'd0;
      word_addr <= '0;
      remaining <= 8'd0;
      cont      <= 1'b0;
      cur_bank  <= 1'b0;
      last_bank <= 1'b1;
      close_cnt <= 1'b0;
    end else begin
      state     <= state_nx;
      busy      <= (state_nx != IDLE);
      mem_we    <= wr_take;
      close_cnt <= (state == CLOSE) ? ~close_cnt : 1'b0;
      bank_full <= bank_set | (bank_full & ~host_release);
      if (wr_take) begin
        mem_data  <= pixels_in;
        mem_addr  <= {cur_bank, word_addr};
        word_addr <= wa_after;
      end
      if (abort)                   REC <= 1'b0;
      else if (take)               REC <= 1'b1;
      else if (state == CAPT && FE) REC <= 1'b0;
      if (start) begin
        remaining <= n_frames;
        cont      <= (n_frames == 8'd0);
        frame_err <= 1'b0;
        drop_cnt  <= 8'd0;
      end else begin
        if (wr_over || (close_done && wa_after != FW)) frame_err <= 1'b1;
        if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
      if (take) begin
        word_addr <= '0;
        cur_bank  <= chosen;
      end
      if (close_done) begin
        last_bank <= cur_bank;
        if (!cont) remaining <= remaining - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_bank_sched.sv
// Directed bench for frame_bank_sched with a shortened frame (16 words).
module tb_frame_bank_sched;
  localparam int AW = 18;
  localparam int FW = 16;

  logic          par_clock = 1'b0;
  logic          rst_n, arm, abort, FS, FE, we_in;
  logic [7:0]    n_frames;
  logic [63:0]   pixels_in;
  logic [1:0]    host_release;
  logic          REC, mem_we, busy, frame_err;
  logic [AW:0]   mem_addr;
  logic [63:0]   mem_data;
  logic [1:0]    bank_full;
  logic [7:0]    drop_cnt;
  int            total = 0;
  int            bad = 0;
  int            pulses;

  frame_bank_sched #(.AW(AW), .FRAME_WORDS(FW)) dut (
    .par_clock(par_clock), .rst_n(rst_n), .arm(arm), .n_frames(n_frames),
    .abort(abort), .FS(FS), .FE(FE), .REC(REC), .we_in(we_in),
    .pixels_in(pixels_in), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .bank_full(bank_full), .host_release(host_release),
    .busy(busy), .frame_err(frame_err), .drop_cnt(drop_cnt)
  );

  always #5 par_clock = ~par_clock;

  task automatic step();
    @(posedge par_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pix(input int i);
    return {32'hC0DE0000 + 32'(i), 32'(i * 3 + 7)};
  endfunction

  task automatic word(input int i, input logic bank, input logic exp_we);
    we_in = 1'b1;
    pixels_in = pix(i);
    step();
    we_in = 1'b0;
    chk("mem_we", 64'(mem_we), 64'(exp_we));
    if (exp_we) begin
      chk("mem_addr", 64'(mem_addr), 64'({bank, AW'(i)}));
      chk("mem_data", mem_data, pix(i));
    end
    if (mem_we) pulses++;
  endtask

  task automatic do_arm(input logic [7:0] n);
    arm = 1'b1;
    n_frames = n;
    step();
    arm = 1'b0;
    chk("busy_arm", 64'(busy), 64'd1);
  endtask

  task automatic release_banks(input logic [1:0] r, input logic [1:0] exp_full);
    host_release = r;
    step();
    host_release = 2'b00;
    chk("bank_full_rel", 64'(bank_full), 64'(exp_full));
  endtask

  // FS, nw words, FE, then the two CLOSE cycles.
  task automatic frame(input int nw, input logic bank);
    FS = 1'b1;
    step();
    FS = 1'b0;
    chk("rec_on", 64'(REC), 64'd1);
    pulses = 0;
    for (int i = 0; i < nw; i++) word(i, bank, i < FW);
    FE = 1'b1;
    step();
    FE = 1'b0;
    chk("rec_off", 64'(REC), 64'd0);
    step();
    step();
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; FS = 1'b0; FE = 1'b0; we_in = 1'b0;
    n_frames = 8'd0; pixels_in = '0; host_release = 2'b00;
    #12;
    chk("rst_rec", 64'(REC), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_full", 64'(bank_full), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    rst_n = 1'b1;
    step();

    // single full frame into bank 0
    do_arm(8'd1);
    frame(FW, 1'b0);
    chk("t1_full", 64'(bank_full), 64'b01);
    chk("t1_err", 64'(frame_err), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_pulses", 64'(pulses), 64'(FW));

    // three frames, no release: bank 1, bank 0, then a drop
    release_banks(2'b01, 2'b00);
    do_arm(8'd3);
    frame(FW, 1'b1);
    chk("t2_full_a", 64'(bank_full), 64'b10);
    frame(FW, 1'b0);
    chk("t2_full_b", 64'(bank_full), 64'b11);
    FS = 1'b1;
    step();
    FS = 1'b0;
    chk("t2_drop", 64'(drop_cnt), 64'd1);
    chk("t2_rec", 64'(REC), 64'd0);
    chk("t2_busy", 64'(busy), 64'd1);
    release_banks(2'b01, 2'b10);
    frame(FW, 1'b0);
    chk("t2_full_c", 64'(bank_full), 64'b11);
    chk("t2_done", 64'(busy), 64'd0);
    chk("t2_err", 64'(frame_err), 64'd0);

    // short frame into bank 1 sets frame_err; next arm clears it
    release_banks(2'b11, 2'b00);
    do_arm(8'd1);
    frame(3, 1'b1);
    chk("t3_full", 64'(bank_full), 64'b10);
    chk("t3_err", 64'(frame_err), 64'd1);
    do_arm(8'd1);
    chk("t3_clr", 64'(frame_err), 64'd0);

    // abort mid-capture into bank 0
    FS = 1'b1;
    step();
    FS = 1'b0;
    chk("t4_rec", 64'(REC), 64'd1);
    for (int i = 0; i < 5; i++) word(i, 1'b0, 1'b1);
    abort = 1'b1;
    we_in = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_rec_off", 64'(REC), 64'd0);
    chk("t4_we", 64'(mem_we), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    step();
    step();
    we_in = 1'b0;
    chk("t4_we2", 64'(mem_we), 64'd0);
    chk("t4_full", 64'(bank_full), 64'b10);

    // overlong frame: 20 words offered, 16 written
    release_banks(2'b10, 2'b00);
    do_arm(8'd1);
    frame(FW + 4, 1'b0);
    chk("t5_pulses", 64'(pulses), 64'(FW));
    chk("t5_err", 64'(frame_err), 64'd1);
    chk("t5_full", 64'(bank_full), 64'b01);

    // fill bank 1, free bank 0, then release bank 0 on the cycle it is set
    do_arm(8'd1);
    frame(FW, 1'b1);
    chk("t6_full_a", 64'(bank_full), 64'b11);
    release_banks(2'b01, 2'b10);
    do_arm(8'd1);
    FS = 1'b1;
    step();
    FS = 1'b0;
    for (int i = 0; i < FW; i++) word(i, 1'b0, 1'b1);
    FE = 1'b1;
    step();
    FE = 1'b0;
    step();
    host_release = 2'b01;
    step();
    host_release = 2'b00;
    chk("t6_set_wins", 64'(bank_full), 64'b11);
    chk("t6_err", 64'(frame_err), 64'd0);

    // async reset mid-capture
    release_banks(2'b01, 2'b10);
    do_arm(8'd1);
    FS = 1'b1;
    step();
    FS = 1'b0;
    word(0, 1'b0, 1'b1);
    we_in = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rec", 64'(REC), 64'd0);
    chk("t6_rst_we", 64'(mem_we), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_full", 64'(bank_full), 64'd0);
    chk("t6_rst_addr", 64'(mem_addr), 64'd0);
    chk("t6_rst_data", mem_data, 64'd0);
    we_in = 1'b0;
    #10;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
